// File: rtl/accum_sched_pkg.sv
// rtl/accum_sched_pkg.sv - shared types and defaults for the accumulator scheduler
package accum_sched_pkg;

  typedef enum logic {S_IDLE, S_BURST} state_e;

  // Defaults shared with the downstream accumulator
  localparam int DATA_W_DEF = 8;
  localparam int BEATS_DEF  = 4;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/accum_rr_sched_rr_pick.sv
// rtl/accum_rr_sched_rr_pick.sv - round-robin pick: rotate by ptr, priority-encode, unrotate
module rr_pick
  import accum_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [IW-1:0]    off;
  logic [IW:0]      sum;

  always_comb begin
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    // Explicit modulo so non-power-of-two N_REQ wraps correctly
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
    gnt_idx = sum[IW-1:0];
    any     = |req;
  end

endmodule

// File: rtl/accum_rr_sched.sv
// rtl/accum_rr_sched.sv - round-robin group scheduler in front of the 4-beat accumulator
module accum_rr_sched
  import accum_sched_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int BEATS  = BEATS_DEF,
  localparam int IW     = idx_w(N_REQ),
  localparam int CW     = idx_w(BEATS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       dn_data,
  output logic                    dn_valid,
  input  logic                    dn_ready,
  output logic                    dn_last,
  output logic [IW-1:0]           dn_src,
  output logic                    busy
);

  state_e            state_q, state_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              dn_valid_q, dn_valid_d;
  logic [DATA_W-1:0] dn_data_q, dn_data_d;
  logic [IW-1:0]     dn_src_q, dn_src_d;
  logic              dn_last_q, dn_last_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              slot_ready;
  logic              gnt_valid;
  logic [DATA_W-1:0] gnt_data;
  logic              accept;
  logic              last_beat;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // dn_ready -> req_ready is the only combinational path through the block
  assign slot_ready = (state_q == S_BURST) && (!dn_valid_q || dn_ready);
  assign accept     = slot_ready && gnt_valid;
  assign last_beat  = (beat_cnt_q == CW'(BEATS - 1));

  always_comb begin
    gnt_valid = 1'b0;
    gnt_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q == IW'(i)) begin
        gnt_valid    = req_valid[i];
        gnt_data     = req_data[i*DATA_W +: DATA_W];
        req_ready[i] = slot_ready;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    dn_valid_d = dn_valid_q;
    dn_data_d  = dn_data_q;
    dn_src_d   = dn_src_q;
    dn_last_d  = dn_last_q;

    if (accept) begin
      dn_valid_d = 1'b1;
      dn_data_d  = gnt_data;
      dn_src_d   = gnt_q;
      dn_last_d  = last_beat;
    end else if (dn_valid_q && dn_ready) begin
      dn_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d    = S_BURST;
          gnt_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        // The grant is held until the full group is accepted, however long that takes
        if (accept) begin
          if (last_beat) begin
            state_d    = S_IDLE;
            rr_ptr_d   = (gnt_q == IW'(N_REQ - 1)) ? '0 : gnt_q + IW'(1);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      dn_valid_q <= 1'b0;
      dn_data_q  <= '0;
      dn_src_q   <= '0;
      dn_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      dn_valid_q <= dn_valid_d;
      dn_data_q  <= dn_data_d;
      dn_src_q   <= dn_src_d;
      dn_last_q  <= dn_last_d;
    end
  end

  assign dn_valid = dn_valid_q;
  assign dn_data  = dn_data_q;
  assign dn_src   = dn_src_q;
  assign dn_last  = dn_last_q;
  assign busy     = (state_q == S_BURST);

endmodule

// File: doc/accum_rr_sched.md
# accum_rr_sched

Round-robin scheduler that shares one downstream 4-beat accumulator port among `N_REQ` valid/ready byte streams. Grants are held for a full group of `BEATS` beats, so one accumulation window never mixes sources. The block has a registered output stage and tags every forwarded beat with its source ID and a last-of-group flag. It sits directly in front of the accumulator's `data_in`/`valid_a`/`ready_a` port.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 8, beat width
- `BEATS`, 4, beats per group; equals the accumulator group size
- `clk` in 1: the single clock
- `rst_n` in 1: reset, synchronous and active-low
- `req_data` in `N_REQ*DATA_W`: requester payloads; requester i occupies bits `[i*DATA_W +: DATA_W]`
- `req_valid` in `N_REQ`: per-requester valid
- `req_ready` out `N_REQ`: per-requester ready
- `dn_data` out `DATA_W`: forwarded beat
- `dn_valid` out 1: forwarded beat valid
- `dn_ready` in 1: downstream ready
- `dn_last` out 1: beat is the `BEATS`-th beat of its group
- `dn_src` out `$clog2(N_REQ)`: source ID of `dn_data`
- `busy` out 1: a grant is held (state is BURST)

## Operation
- **States:**
  - IDLE: no grant.
  - BURST: grant held by `gnt_id`.
- **IDLE:**
  - If any `req_valid` is high, pick the first set bit scanning upward from `rr_ptr`, wrapping modulo `N_REQ`.
  - On that edge: `gnt_id` <= pick, `beat_cnt` <= 0, state <= BURST.
  - If no `req_valid` is high, stay in IDLE.
  - `req_ready` is all-zero in IDLE.
- **BURST:**
  - `req_ready[gnt_id] = !dn_valid | dn_ready`. All other `req_ready` bits are 0.
  - Accept condition: `req_valid[gnt_id] && req_ready[gnt_id]`.
  - On accept: the output register loads `req_data` slice, `gnt_id`, and `dn_last = (beat_cnt == BEATS-1)`; `beat_cnt` increments.
  - On the accept with `beat_cnt == BEATS-1`: state <= IDLE, `rr_ptr` <= (`gnt_id`+1) mod `N_REQ`, `beat_cnt` <= 0.
- **Held grant:** a granted requester that drops `req_valid` mid-group keeps the grant indefinitely. There is no timeout and no preemption.
- **Output register:**
  - `dn_valid` is set on accept.
  - `dn_valid` is cleared on `dn_valid && dn_ready` with no accept on the same edge.
  - Accept and drain on the same edge: `dn_valid` stays 1 with the new beat.
  - `dn_data`/`dn_src`/`dn_last` are stable while `dn_valid && !dn_ready`.
- **Widths:** `beat_cnt` is `$clog2(BEATS)` bits and wraps to 0 after `BEATS-1`. `rr_ptr` and `gnt_id` are `$clog2(N_REQ)` bits. When `N_REQ` is not a power of 2, the wrap is explicit: `N_REQ-1` -> 0.
- **Reset** (`rst_n` low at a `clk` edge), including mid-group:
  - state IDLE; `rr_ptr`, `gnt_id`, `beat_cnt` = 0.
  - `dn_valid`=0, `dn_data`=0, `dn_src`=0, `dn_last`=0, `busy`=0, `req_ready`=0.
  - A partial group is discarded; the accumulator is reset in the same domain.

## Timing
- `req_ready`, `busy`, `dn_*` are all registered or decoded from registered state only. The only combinational path is `dn_ready` -> `req_ready`.
- **Arbitration latency:** a requester raising `req_valid` at edge k, with state IDLE, is granted at edge k+1. Its first beat can be accepted at edge k+2.
- **Group cost:** with `dn_ready` held high, a group costs `BEATS`+1 cycles (1 arbitration bubble). `dn_valid` first rises one cycle after the first accept.
- **Back-pressure:** with `dn_ready` low and `dn_valid` high, `req_ready` is 0. The stall is lossless.
- **Fairness:** any continuously requesting source is granted within `N_REQ-1` groups.

## Structure
- Package `accum_sched_pkg` holds:
  - the state enum `{S_IDLE, S_BURST}`;
  - the `DATA_W`/`BEATS` defaults, shared with the accumulator;
  - the function `idx_w(n) = $clog2(n)`.
- Sub-module `rr_pick`: combinational, inputs `req[N_REQ]` and `ptr`, outputs `gnt_idx` and `any`. It implements the rotate-priority-encode-unrotate pick and is instantiated once.
- Top level holds the FSM, `beat_cnt`, `rr_ptr`, and the output register.

## Test plan
- **Single source:** reset, then `req_valid[2]`=1 with data 1,2,3,4 and `dn_ready`=1.
  - Grant to 2 one cycle later.
  - `dn_data` = 1,2,3,4 on consecutive cycles, `dn_src`=2, `dn_last` only on 4.
  - `rr_ptr`=3 afterwards.
- **All four requesting continuously:** groups are granted in order 0,1,2,3,0. No group is interleaved. Each group spans 5 cycles.
- **Back-pressure:** `dn_ready`=0 after the 2nd beat for 3 cycles.
  - `dn_data` holds beat 2; `req_ready[gnt]`=0.
  - On release, beats 3 and 4 follow with no loss or duplication.
- **Gapped source:** the granted source deasserts `req_valid` after beat 2 while source 1 requests. The grant stays on the original source; source 1 is served only after beat 4.
- **Reset mid-group:** `rst_n`=0 for 1 edge after beat 3 of source 1.
  - Next cycle: `dn_valid`=0, `busy`=0, `rr_ptr`=0.
  - A subsequent request from 0 and 1 grants 0 first.
- **`N_REQ`=3 wrap:** after a group from source 2, `rr_ptr`=0, and requests from {0,2} grant 0.
